// File: rtl/mux_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mux_pkg : select encodings and default data width for mux
// Rev 1.0
// ------------------------------------------------------------------
package mux_pkg;

  localparam int          DEFAULT_WIDTH = 1;

  localparam logic [1:0]  SEL_A = 2'b00;
  localparam logic [1:0]  SEL_B = 2'b01;
  localparam logic [1:0]  SEL_C = 2'b10;
  localparam logic [1:0]  SEL_D = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mux4_core.sv
`default_nettype none
// ------------------------------------------------------------------
// mux4_core : combinational 4:1 selector, unknown select yields zero
// Rev 1.0
// ------------------------------------------------------------------
module mux4_core
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o
);

  // An X/Z select matches no item, so the default keeps the output at zero.
  always_comb begin
    o = '0;
    case (sel)
      SEL_A:   o = a;
      SEL_B:   o = b;
      SEL_C:   o = c;
      SEL_D:   o = d;
      default: o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mux.sv
`default_nettype none
// ------------------------------------------------------------------
// mux : registered 4:1 multiplexer with enable and synchronous reset.
//       MUX_HOLD_EN defined: e=0 holds y; undefined: e=0 clears y.
// Rev 1.0
// ------------------------------------------------------------------
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic             s1,
  input  logic             s2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] core_o;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  assign sel = {s1, s2};

  mux4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .sel (sel),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .o   (core_o)
  );

  always_comb begin
    y_d = y_q;
    if (e) begin
      y_d = core_o;
    end else begin
`ifdef MUX_HOLD_EN
      y_d = y_q;
`else
      y_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_mux.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mux : directed vector bench for mux (WIDTH=1 and WIDTH=8 instances)
// Rev 1.0
// ------------------------------------------------------------------
module tb_mux;

`ifdef MUX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk;
  logic rst, e, s1, s2, a, b, c, d;
  logic y;
  logic rst8, e8, s1_8, s2_8;
  logic [7:0] a8, b8, c8, d8, y8;

  int tests;
  int failed;

  typedef struct {
    logic rst;
    logic e;
    logic s1;
    logic s2;
    logic a;
    logic b;
    logic c;
    logic d;
    logic exp_y;
  } vec_t;

  vec_t vec [14];

  mux #(.WIDTH(1)) dut1 (
    .clk (clk), .rst (rst), .e (e), .s1 (s1), .s2 (s2),
    .a (a), .b (b), .c (c), .d (d), .y (y)
  );

  mux #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst8), .e (e8), .s1 (s1_8), .s2 (s2_8),
    .a (a8), .b (b8), .c (c8), .d (d8), .y (y8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: y=%h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] exp8;
    tests  = 0;
    failed = 0;

    //           rst  e    s1   s2   a    b    c    d    y
    vec[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
    vec[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1};
    vec[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
    vec[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
    vec[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
    vec[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
    vec[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,HOLD};
    vec[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1};
    vec[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
    vec[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1};
    vec[10] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,HOLD};
    vec[11] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0};
    vec[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0};
    vec[13] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};

    rst = 1'b1; e = 1'b0; s1 = 1'b0; s2 = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0;
    rst8 = 1'b1; e8 = 1'b0; s1_8 = 1'b0; s2_8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 8'h00; d8 = 8'h00;

    for (int i = 0; i < 14; i++) begin
      rst = vec[i].rst; e = vec[i].e; s1 = vec[i].s1; s2 = vec[i].s2;
      a = vec[i].a; b = vec[i].b; c = vec[i].c; d = vec[i].d;
      step();
      check($sformatf("vec%0d", i), {7'd0, y}, {7'd0, vec[i].exp_y});
    end

    // Latency: a new select applied mid-cycle must not show until the next edge.
    rst = 1'b0; e = 1'b1; s1 = 1'b1; s2 = 1'b1; a = 1'b0; d = 1'b1;
    step();
    check("lat_pre", {7'd0, y}, 8'd1);
    s1 = 1'b0; s2 = 1'b0;
    #2;
    check("lat_mid", {7'd0, y}, 8'd1);
    step();
    check("lat_post", {7'd0, y}, 8'd0);

    // Glitch on d between edges with sel=11 must be invisible on y.
    s1 = 1'b1; s2 = 1'b1; d = 1'b1;
    step();
    check("glitch_base", {7'd0, y}, 8'd1);
    #1 d = 1'b0;
    #1 check("glitch_low", {7'd0, y}, 8'd1);
    #1 d = 1'b1;
    #1 check("glitch_high", {7'd0, y}, 8'd1);
    step();
    check("glitch_edge", {7'd0, y}, 8'd1);

    // WIDTH=8 instance.
    step();
    check("w8_reset", y8, 8'h00);
    rst8 = 1'b0; e8 = 1'b1; s1_8 = 1'b1; s2_8 = 1'b0;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    step();
    check("w8_selc", y8, 8'h33);
    s2_8 = 1'b1;
    step();
    check("w8_seld", y8, 8'h44);
    s1_8 = 1'b0; s2_8 = 1'b1;
    step();
    check("w8_selb", y8, 8'h22);
    s1_8 = 1'bx; s2_8 = 1'b0;
    step();
    // A two-state simulator resolves the X to a concrete level; expect that selection then.
    if ($isunknown(s1_8)) exp8 = 8'h00;
    else exp8 = s1_8 ? 8'h33 : 8'h11;
    check("w8_xsel", y8, exp8);
    s1_8 = 1'b0; e8 = 1'b0;
    step();
    check("w8_en_off", y8, HOLD ? exp8 : 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter WIDTH, default 1, is the bit width of each data input and of y.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  is the reset: synchronous, active-high.
REQ-004 Port e  input  1  is the enable; 1 means select and register, 0 means output disabled.
REQ-005 Port s1  input  1  is the select MSB.
REQ-006 Port s2  input  1  is the select LSB.
REQ-007 Port a  input  WIDTH  is data input 0.
REQ-008 Port b  input  WIDTH  is data input 1.
REQ-009 Port c  input  WIDTH  is data input 2.
REQ-010 Port d  input  WIDTH  is data input 3.
REQ-011 Port y  output  WIDTH  is the registered mux result.
REQ-012 The positional port order SHALL be clk, rst, e, s1, s2, a, b, c, d, y.

Function
REQ-013 The select value sel SHALL be {s1,s2} and decode as follows: 2'b00 selects a, 2'b01 selects b, 2'b10 selects c, 2'b11 selects d.
REQ-014 When e=1 and rst=0, y SHALL take the selected input at the next rising clk edge, giving 1-cycle latency.
REQ-015 When e=0 and rst=0, y SHALL become all-zeros at the next rising clk edge, unless MUX_HOLD_EN is defined (see REQ-021).
REQ-016 y SHALL change only on rising clk edges; input changes between edges SHALL have no effect on y.
REQ-017 An X/Z value on s1 or s2 while e=1 SHALL drive y to all-zeros, not X.
REQ-018 Simultaneous changes of e, the selects and the data inputs before an edge SHALL resolve using the values sampled at that edge only.

Reset
REQ-019 When rst=1 at a rising clk edge, y SHALL become all-zeros, overriding e and the selects.
REQ-020 Asserting reset mid-stream SHALL take effect on the sampled edge; the first edge after rst deasserts SHALL load normally per REQ-014 and REQ-015.

Configuration
REQ-021 When the macro MUX_HOLD_EN is defined, e=0 SHALL hold y at its previous value; when it is undefined, e=0 SHALL clear y to zero; reset clears y in both builds.

Structure
REQ-022 A shared package mux_pkg SHALL hold the select encoding constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10 and SEL_D=2'b11, plus the default WIDTH.
REQ-023 The combinational 4:1 selection SHALL be a sub-module mux4_core (ports: sel, a, b, c, d, o), and mux SHALL contain only the enable, reset and output register logic.

Verification
REQ-024 Reset: rst=1, e=1, sel=00, a=1, one edge -> y=0; deassert rst -> after the next edge y=1.
REQ-025 Select sweep: e=1, a=0, b=1, c=0, d=1, with sel stepped 00, 01, 10, 11 on successive edges -> y=0, 1, 0, 1, each one cycle after its select is applied.
REQ-026 Enable off: y=1, then e=0 -> after the next edge y=0 (default build) or y=1 (MUX_HOLD_EN build).
REQ-027 Between-edge glitch: toggle d 1→0→1 between edges with sel=11 and e=1 -> y stays 1 with no intermediate change.
REQ-028 WIDTH=8: a=8'h11, b=8'h22, c=8'h33, d=8'h44, sel=10, e=1 -> y=8'h33 one cycle later; X on s1 -> y=8'h00.
